// File: rtl/lfsr_stream_arbiter_pkg.sv
// Shared definitions for the LFSR stream arbiter: LFSR width, reset seed,
// the 10-bit step recurrence and the arbiter state encoding.
package lfsr_pkg;

   localparam int          LFSR_W    = 10;
   localparam logic [9:0]  LFSR_SEED = 10'h0A0;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   // Next LFSR state from the current state r.
   function automatic logic [LFSR_W-1:0] lfsr10_next(input logic [LFSR_W-1:0] r);
      logic [LFSR_W-1:0] n;
      n[0]   = r[9] ^ r[8] ^ r[7] ^ r[1] ^ r[2];
      n[7:1] = r[6:0];
      n[8]   = r[7] ^ r[6] ^ r[5] ^ r[3] ^ r[4];
      n[9]   = r[8];
      return n;
   endfunction

endpackage

// File: rtl/lfsr_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   int w_pos;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_pos = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_pos = (int'(i_ptr) + k) % NREQ;
         if (!o_any && i_req[w_pos]) begin
            o_any        = 1'b1;
            o_gnt[w_pos] = 1'b1;
            o_idx        = IDW'(w_pos);
         end
      end
   end

endmodule

// File: rtl/lfsr_stream_arbiter.sv
// Shares one 10-bit LFSR among NREQ requesters: round-robin burst grants,
// valid/ready beat streaming with last flag and id, and IDLE-only reseeding.
module lfsr_stream_arbiter
   import lfsr_pkg::*;
#(
   parameter int               NREQ = 4,
   parameter int               IDW  = 2,
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic [NREQ-1:0]     i_req,
   input  logic [NREQ*4-1:0]   i_req_len,
   output logic [NREQ-1:0]     o_gnt,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [LFSR_W-1:0]   o_out_data,
   output logic                o_out_last,
   output logic [IDW-1:0]      o_out_id,
   input  logic                i_seed_valid,
   input  logic [LFSR_W-1:0]   i_seed_data,
   output logic                o_seed_ready,
   output logic                o_busy
);

   state_e              r_state, w_state_next;
   logic [LFSR_W-1:0]   r_lfsr, w_lfsr_next;
   logic [IDW-1:0]      r_rr_ptr, w_rr_ptr_next;
   logic [4:0]          r_count, w_count_next;
   logic [NREQ-1:0]     r_gnt, w_gnt_next;
   logic [IDW-1:0]      r_id, w_id_next;

   logic [NREQ-1:0]     w_pick_gnt;
   logic [IDW-1:0]      w_pick_idx;
   logic                w_pick_any;
   logic [3:0]          w_sel_len;
   logic                w_accept;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .i_req (i_req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   assign w_sel_len = i_req_len[{w_pick_idx, 2'b00} +: 4];
   assign w_accept  = (r_state == BURST) && i_out_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_lfsr   <= SEED;
         r_rr_ptr <= '0;
         r_count  <= '0;
         r_gnt    <= '0;
         r_id     <= '0;
      end else begin
         r_state  <= w_state_next;
         r_lfsr   <= w_lfsr_next;
         r_rr_ptr <= w_rr_ptr_next;
         r_count  <= w_count_next;
         r_gnt    <= w_gnt_next;
         r_id     <= w_id_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_lfsr_next   = r_lfsr;
      w_rr_ptr_next = r_rr_ptr;
      w_count_next  = r_count;
      w_gnt_next    = r_gnt;
      w_id_next     = r_id;
      case (r_state)
         IDLE: begin
            // A reseed pre-empts arbitration for this cycle.
            if (i_seed_valid) begin
               w_lfsr_next = (i_seed_data == '0) ? SEED : i_seed_data;
            end else if (w_pick_any) begin
               w_gnt_next   = w_pick_gnt;
               w_id_next    = w_pick_idx;
               w_count_next = {(w_sel_len == 4'd0), w_sel_len};
               w_state_next = BURST;
            end
         end
         BURST: begin
            if (w_accept) begin
               w_lfsr_next  = lfsr10_next(r_lfsr);
               w_count_next = r_count - 5'd1;
               if (r_count == 5'd1) begin
                  w_state_next  = IDLE;
                  w_gnt_next    = '0;
                  w_rr_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign o_gnt        = r_gnt;
   assign o_out_valid  = (r_state == BURST);
   assign o_out_data   = r_lfsr;
   assign o_out_last   = (r_state == BURST) && (r_count == 5'd1);
   assign o_out_id     = r_id;
   assign o_seed_ready = (r_state == IDLE);
   assign o_busy       = (r_state == BURST);

endmodule

// File: tb/tb_lfsr_stream_arbiter.sv
// Directed bench for lfsr_stream_arbiter with hand-computed LFSR values.
module tb_lfsr_stream_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic [3:0]  gnt;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  out_data;
   logic        out_last;
   logic [1:0]  out_id;
   logic        seed_valid;
   logic [9:0]  seed_data;
   logic        seed_ready;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lfsr_stream_arbiter #(.NREQ(4), .IDW(2), .SEED(10'h0A0)) dut (
      .i_clock      (clk),
      .i_reset      (reset),
      .i_req        (req),
      .i_req_len    (req_len),
      .o_gnt        (gnt),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_out_data   (out_data),
      .o_out_last   (out_last),
      .o_out_id     (out_id),
      .i_seed_valid (seed_valid),
      .i_seed_data  (seed_data),
      .o_seed_ready (seed_ready),
      .o_busy       (busy)
   );

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      req        = '0;
      seed_valid = 1'b0;
      seed_data  = '0;
      out_ready  = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [9:0] rr_data [5];
   int         rr_ids  [5];

   initial begin
      rr_data = '{10'h0A0, 10'h041, 10'h182, 10'h305, 10'h20B};
      rr_ids  = '{0, 1, 2, 3, 0};
      req_len = '0;

      // Reset state and a 3-beat burst from requester 0
      do_reset();
      expect_eq("rst_gnt",   gnt, 0);
      expect_eq("rst_valid", out_valid, 0);
      expect_eq("rst_last",  out_last, 0);
      expect_eq("rst_id",    out_id, 0);
      expect_eq("rst_busy",  busy, 0);
      expect_eq("rst_sready", seed_ready, 1);
      req = 4'b0001; req_len = 16'h0003;
      tick();
      req = 4'b0000;
      expect_eq("b1_gnt",   gnt, 4'b0001);
      expect_eq("b1_busy",  busy, 1);
      expect_eq("b1_d0",    out_data, 10'h0A0);
      expect_eq("b1_l0",    out_last, 0);
      tick();
      expect_eq("b1_d1",    out_data, 10'h041);
      expect_eq("b1_l1",    out_last, 0);
      tick();
      expect_eq("b1_d2",    out_data, 10'h182);
      expect_eq("b1_l2",    out_last, 1);
      tick();
      expect_eq("b1_end_valid", out_valid, 0);
      expect_eq("b1_end_gnt",   gnt, 0);

      // Round-robin with all four requesting, length 1
      do_reset();
      req = 4'b1111; req_len = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_eq($sformatf("rr%0d_valid", i), out_valid, 1);
         expect_eq($sformatf("rr%0d_gnt", i),   gnt, 4'b0001 << rr_ids[i]);
         expect_eq($sformatf("rr%0d_id", i),    out_id, rr_ids[i]);
         expect_eq($sformatf("rr%0d_last", i),  out_last, 1);
         expect_eq($sformatf("rr%0d_data", i),  out_data, rr_data[i]);
         tick();
         expect_eq($sformatf("rr%0d_gap_valid", i), out_valid, 0);
         expect_eq($sformatf("rr%0d_gap_gnt", i),   gnt, 0);
      end
      req = '0;

      // Backpressure on the first beat
      do_reset();
      req = 4'b0001; req_len = 16'h0002; out_ready = 1'b0;
      tick();
      req = '0;
      for (int i = 0; i < 5; i++) begin
         expect_eq($sformatf("bp%0d_valid", i), out_valid, 1);
         expect_eq($sformatf("bp%0d_data", i),  out_data, 10'h0A0);
         expect_eq($sformatf("bp%0d_last", i),  out_last, 0);
         if (i < 4) tick();
      end
      out_ready = 1'b1;
      tick();
      expect_eq("bp_d1",   out_data, 10'h041);
      expect_eq("bp_l1",   out_last, 1);
      tick();
      expect_eq("bp_end_valid", out_valid, 0);

      // Reseed: explicit seed, then zero seed colliding with a request
      do_reset();
      seed_valid = 1'b1; seed_data = 10'h041;
      tick();
      seed_valid = 1'b0;
      req = 4'b0001; req_len = 16'h0001;
      tick();
      req = '0;
      expect_eq("rs1_data", out_data, 10'h041);
      expect_eq("rs1_last", out_last, 1);
      tick();
      expect_eq("rs1_end_valid", out_valid, 0);
      seed_valid = 1'b1; seed_data = 10'h000; req = 4'b0001;
      expect_eq("rs2_sready", seed_ready, 1);
      tick();
      seed_valid = 1'b0;
      expect_eq("rs2_hold_valid", out_valid, 0);
      expect_eq("rs2_hold_gnt",   gnt, 0);
      tick();
      req = '0;
      expect_eq("rs2_gnt",    gnt, 4'b0001);
      expect_eq("rs2_data",   out_data, 10'h0A0);
      expect_eq("rs2_sready_busy", seed_ready, 0);
      tick();

      // Length 0 encodes 16 beats; then reset mid-burst
      do_reset();
      req = 4'b0001; req_len = 16'h0000;
      tick();
      req = '0;
      for (int b = 1; b <= 16; b++) begin
         if (b == 1) expect_eq("l16_d0", out_data, 10'h0A0);
         expect_eq($sformatf("l16_b%0d_last", b), out_last, (b == 16));
         expect_eq($sformatf("l16_b%0d_valid", b), out_valid, 1);
         tick();
      end
      expect_eq("l16_end_valid", out_valid, 0);
      req = 4'b0001;
      tick();
      req = '0;
      for (int b = 1; b < 5; b++) tick();
      expect_eq("ab_b5_valid", out_valid, 1);
      expect_eq("ab_b5_last",  out_last, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_eq("ab_valid", out_valid, 0);
      expect_eq("ab_gnt",   gnt, 0);
      req = 4'b0001; req_len = 16'h0001;
      tick();
      req = '0;
      expect_eq("ab_restart_data", out_data, 10'h0A0);
      expect_eq("ab_restart_last", out_last, 1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lfsr_stream_arbiter.md
Name: lfsr_stream_arbiter

Overview:
- Shares one 10-bit LFSR pattern generator among NREQ requesters.
- Each requester asks for a burst of 1..16 LFSR values; grants are issued round-robin.
- Values are streamed over a valid/ready output with a burst-last flag and a requester id.
- Sits between the shared LFSR datapath and the test-pattern consumers. Also owns reseeding of the generator.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, id width; must satisfy 2**IDW >= NREQ.
- SEED, 10'h0A0, reset seed and substitute for an all-zero seed.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester burst request, level.
- req_len  in  NREQ*4  burst length per requester, slice i = bits [4i+3:4i]; 0 encodes 16.
- gnt  out  NREQ  one-hot grant, held for the whole burst.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  10  current LFSR state.
- out_last  out  1  final beat of the burst.
- out_id  out  IDW  index of the granted requester.
- seed_valid  in  1  reseed request.
- seed_data  in  10  new seed.
- seed_ready  out  1  high only in IDLE.
- busy  out  1  high in BURST.

Behaviour:
- Reset (sync, active-high) sets:
  - lfsr=SEED, state=IDLE, rr_ptr=0, count=0;
  - gnt=0, out_valid=0, out_last=0, out_id=0, busy=0.
- Reset mid-burst aborts the burst immediately, with no last beat.
- LFSR step (fixed team recurrence), computed from the old state r:
  - n[0] = r9^r8^r7^r1^r2;
  - n[8] = r7^r6^r5^r3^r4;
  - n[9] = r8;
  - n[k] = r[k-1] for k = 1..7.
- The LFSR advances only on an accepted beat (out_valid && out_ready). It holds otherwise and is never reset between bursts.
- States:
  - IDLE: seed_ready=1, out_valid=0, gnt=0.
  - BURST: gnt, out_id and busy are valid; out_valid=1.
- IDLE priority, evaluated each cycle:
  - (1) If seed_valid, load lfsr with seed_data (10'h000 is replaced by SEED). Stay in IDLE and do not arbitrate this cycle.
  - (2) Else if any req bit is set, select the first set index searching from rr_ptr upward with wrap-around. Latch its req_len into count (0 -> 16), set gnt one-hot, and go to BURST.
- Latency: a req sampled in IDLE at edge t gives gnt=1 and out_valid=1 from t+1.
- BURST:
  - out_data = lfsr;
  - out_last = (count == 1);
  - each accepted beat decrements count.
- End of burst: when the last beat is accepted, state returns to IDLE, gnt drops next cycle, and rr_ptr = (granted index + 1) mod NREQ.
- A minimum of one IDLE cycle separates bursts. With continuous requests, back-to-back bursts therefore start every (len+1) accepted cycles.
- out_valid stays high while out_ready is low; out_data and out_last are stable.
- req and req_len are sampled only in IDLE.
  - A req dropping mid-burst is ignored; the burst completes.
  - A requester holds req until it sees gnt.
- seed_valid in BURST is ignored (seed_ready=0). The source retries.
- Single requester: it is re-granted after each IDLE gap; no starvation. Every requester with req held is served within NREQ bursts.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W=10, LFSR_SEED=10'h0A0;
  - function lfsr10_next (the recurrence above);
  - state enum {IDLE, BURST}.
- One sub-module is natural: rr_pick (NREQ request vector + rr_ptr -> one-hot grant + index, combinational). The LFSR register and step stay inside the arbiter.

Test Plan:
- Reset, then req=0001, len0=3, out_ready=1:
  - gnt=0001 one cycle after req;
  - out_data 0x0A0, 0x041, 0x182;
  - out_last on the third beat;
  - then IDLE with gnt=0.
- req=1111 held, all len=1:
  - grant order 0,1,2,3,0;
  - out_id follows;
  - each burst is separated by exactly one IDLE cycle.
- Backpressure: len0=2, out_ready low for 5 cycles on the first beat:
  - out_valid held;
  - out_data stays 0x0A0 and the LFSR does not advance;
  - then 0x0A0, 0x041 are accepted.
- Reseed: seed_valid with seed_data=0x000 together with req=0001:
  - seed wins and seed_ready=1;
  - the next burst starts one cycle later, beginning at 0x0A0.
  - seed_data=0x041 then burst len=1 -> out_data 0x041.
- req_len=0 -> 16 beats, out_last only on beat 16. Reset asserted at beat 5 -> out_valid=0 and gnt=0 next cycle; the LFSR restarts at 0x0A0.
